rdcla_checker: RTL and testbench
================================

RDCLA_CHECKER -- requirements
Module: rdcla_checker

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and sum width.
REQ-002 Parameter DEPTH, default 8 (power of two, at least 2), SHALL set the expected-result queue depth.
REQ-003 Parameter CW, default 16, SHALL set the width of both event counters.
REQ-004 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: SHALL be the asynchronous, active-high reset.
REQ-006 Port op_valid, input, 1: SHALL qualify one operand set issued to the adder under test.
REQ-007 Ports a and b, input, WIDTH each: SHALL be the issued operands.
REQ-008 Port cin, input, 1: SHALL be the issued carry-in.
REQ-009 Port res_valid, input, 1: SHALL qualify one result returned by the adder under test.
REQ-010 Ports s (input, WIDTH) and cout (input, 1): SHALL be the returned sum and carry-out.
REQ-011 Port pass_count, output, CW: SHALL count matching results.
REQ-012 Port fail_count, output, CW: SHALL count mismatching results.
REQ-013 Port mismatch, output, 1: SHALL pulse for one cycle for each mismatch.
REQ-014 Port ovf_err, output, 1: SHALL be a sticky flag for an operand arriving while the queue is full.
REQ-015 Port unf_err, output, 1: SHALL be a sticky flag for a result arriving while the queue is empty.
REQ-016 Port halted, output, 1: SHALL be high while the FSM is in state HALT.
REQ-017 Port halt_on_fail, input, 1: SHALL, when high, make the first mismatch stop checking.
REQ-018 Port resume, input, 1: SHALL return the FSM from HALT to RUN.

Function
REQ-019 On an accepted op_valid, the block SHALL compute {exp_cout, exp_s} = a + b + cin, WIDTH+1 bits with no truncation, and push it into a FIFO of depth DEPTH.
REQ-020 On an accepted res_valid, the block SHALL pop the FIFO head and compare it with {cout, s}.
- Match: pass_count increments.
- Mismatch: fail_count increments and mismatch is high on the following cycle.
- Latency from res_valid to the counter update and mismatch is 1 cycle.
REQ-021 The FIFO SHALL be in-order, and its pointers SHALL wrap modulo DEPTH.
REQ-022 If push and pop occur in the same cycle, both SHALL be performed, including when the FIFO is full (pop frees the slot first) and when it is empty (push only; the pop is counted as underflow).
REQ-023 If op_valid arrives while the FIFO is full and no pop occurs that cycle, the operand SHALL be dropped and ovf_err set.
REQ-024 If res_valid arrives while the FIFO is empty, no count SHALL change and unf_err SHALL be set.
REQ-025 Both counters SHALL saturate at 2^CW-1 and SHALL NOT wrap.
REQ-026 FSM states SHALL be RUN and HALT.
- RUN -> HALT on a mismatch while halt_on_fail = 1.
- HALT -> RUN on resume = 1.
- All other conditions hold the current state.
REQ-027 In HALT, op_valid and res_valid SHALL be ignored: no push, no pop, no counts, no error flags.
REQ-028 The mismatch that causes the transition into HALT SHALL still be counted.
REQ-029 If resume and a mismatch occur in the same cycle while in RUN, the mismatch SHALL take priority.

Reset
REQ-030 While rst is high, the block SHALL hold pass_count = 0, fail_count = 0, mismatch = 0, ovf_err = 0, unf_err = 0, halted = 0, FSM = RUN, and the FIFO empty with both pointers at 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued expected values immediately (asynchronous); the first result after reset SHALL be treated as underflow.

Verification
REQ-032 Stimulus: a = 123, b = 123, cin = 1, followed 5 cycles later by res s = 247, cout = 0 -> pass_count = 1, fail_count = 0, mismatch never asserted.
REQ-033 Stimulus: a = 0xFFFFFFFF, b = 1, cin = 0, returned s = 0, cout = 0 -> fail_count = 1 and a single mismatch pulse (expected cout = 1).
REQ-034 Stimulus: 9 consecutive op_valid with no results, DEPTH = 8 -> ovf_err = 1 after the 9th; then 8 correct results -> pass_count = 8.
REQ-035 Stimulus: res_valid after reset with no prior op -> unf_err = 1, both counters remain 0.
REQ-036 Stimulus: halt_on_fail = 1, one bad result followed by 3 good results -> fail_count = 1, pass_count = 0, halted = 1; after resume and 1 more op/good-result pair -> pass_count = 1, halted = 0.
REQ-037 Stimulus: rst pulsed with 3 ops queued -> all outputs return to 0 asynchronously and the next result sets unf_err.

Source files
------------

// File: rtl/rdcla_checker.sv
// Scoreboard for an adder under test: queues a+b+cin for each issued operand set and
// compares in order against returned {cout, s}, with pass/fail counters and halt-on-fail.
module rdcla_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    input  logic             halt_on_fail,
    input  logic             resume,
    output logic [CW-1:0]    pass_count,
    output logic [CW-1:0]    fail_count,
    output logic             mismatch,
    output logic             ovf_err,
    output logic             unf_err,
    output logic             halted
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            state_r;
    logic              halted_r;
    logic [WIDTH:0]    mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic [CW-1:0]     pass_count_r;
    logic [CW-1:0]     fail_count_r;
    logic              mismatch_r;
    logic              ovf_err_r;
    logic              unf_err_r;

    logic              run_s;
    logic              empty_s;
    logic              full_s;
    logic              push_req_s;
    logic              pop_req_s;
    logic              do_push_s;
    logic              do_pop_s;
    logic              ovf_evt_s;
    logic              unf_evt_s;
    logic              pass_evt_s;
    logic              fail_evt_s;
    logic [WIDTH:0]    exp_sum_s;
    logic [WIDTH:0]    head_s;

    // Queue handshake decisions; a pop on a full queue frees the slot the push then takes.
    always_comb begin
        run_s      = (state_r == RUN);
        empty_s    = (count_r == {(AW+1){1'b0}});
        full_s     = (count_r == (AW+1)'(DEPTH));
        push_req_s = run_s & op_valid;
        pop_req_s  = run_s & res_valid;
        do_pop_s   = pop_req_s & ~empty_s;
        do_push_s  = 1'b0;
        if (push_req_s && (!full_s || do_pop_s)) begin
            do_push_s = 1'b1;
        end else begin
            do_push_s = 1'b0;
        end
        ovf_evt_s  = push_req_s & full_s & ~do_pop_s;
        unf_evt_s  = pop_req_s & empty_s;
        exp_sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        head_s     = mem_r[rd_ptr_r];
        pass_evt_s = do_pop_s & (head_s == {cout, s});
        fail_evt_s = do_pop_s & (head_s != {cout, s});
    end

    // Expected-result storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= exp_sum_s;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating counters, one-cycle mismatch pulse and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_count_r <= {CW{1'b0}};
            fail_count_r <= {CW{1'b0}};
            mismatch_r   <= 1'b0;
            ovf_err_r    <= 1'b0;
            unf_err_r    <= 1'b0;
        end else begin
            if (pass_evt_s && (pass_count_r != {CW{1'b1}})) begin
                pass_count_r <= pass_count_r + CW'(1);
            end
            if (fail_evt_s && (fail_count_r != {CW{1'b1}})) begin
                fail_count_r <= fail_count_r + CW'(1);
            end
            mismatch_r <= fail_evt_s;
            if (ovf_evt_s) begin
                ovf_err_r <= 1'b1;
            end
            if (unf_evt_s) begin
                unf_err_r <= 1'b1;
            end
        end
    end

    // Run/halt control; a halting mismatch beats a simultaneous resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= RUN;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (fail_evt_s && halt_on_fail) begin
                        state_r  <= HALT;
                        halted_r <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= RUN;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    assign pass_count = pass_count_r;
    assign fail_count = fail_count_r;
    assign mismatch   = mismatch_r;
    assign ovf_err    = ovf_err_r;
    assign unf_err    = unf_err_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_rdcla_checker.sv
// Directed bench for rdcla_checker: hand-computed sums, queue boundaries, halt/resume
// and asynchronous reset, each compared with an immediate assertion.
module tb_rdcla_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        res_valid;
    logic [31:0] s;
    logic        cout;
    logic        halt_on_fail;
    logic        resume;
    logic [15:0] pass_count;
    logic [15:0] fail_count;
    logic        mismatch;
    logic        ovf_err;
    logic        unf_err;
    logic        halted;

    int tests = 0;
    int fails = 0;

    rdcla_checker #(.WIDTH(32), .DEPTH(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .a(a), .b(b), .cin(cin),
        .res_valid(res_valid), .s(s), .cout(cout), .halt_on_fail(halt_on_fail),
        .resume(resume), .pass_count(pass_count), .fail_count(fail_count),
        .mismatch(mismatch), .ovf_err(ovf_err), .unf_err(unf_err), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        op_valid  = 1'b0;
        res_valid = 1'b0;
        resume    = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic ic);
        op_valid = 1'b1;
        a = ia;
        b = ib;
        cin = ic;
        step();
        op_valid = 1'b0;
    endtask

    task automatic res(input logic [31:0] is, input logic ic);
        res_valid = 1'b1;
        s = is;
        cout = ic;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; res_valid = 1'b0; resume = 1'b0; halt_on_fail = 1'b0;
        a = 32'd0; b = 32'd0; cin = 1'b0; s = 32'd0; cout = 1'b0;
        step();
        step();
        check("rst_pass", pass_count, 32'd0);
        check("rst_fail", fail_count, 32'd0);
        check("rst_mismatch", mismatch, 32'd0);
        check("rst_ovf", ovf_err, 32'd0);
        check("rst_unf", unf_err, 32'd0);
        check("rst_halted", halted, 32'd0);
        rst = 1'b0;
        step();

        // 123 + 123 + 1 = 247, result returned 5 cycles after issue
        op(32'd123, 32'd123, 1'b1);
        repeat (4) step();
        res(32'd247, 1'b0);
        check("basic_pass", pass_count, 32'd1);
        check("basic_fail", fail_count, 32'd0);
        check("basic_mismatch", mismatch, 32'd0);
        step();
        check("basic_mismatch_after", mismatch, 32'd0);

        // 0xFFFFFFFF + 1 carries out; returned cout = 0 is wrong
        do_reset();
        op(32'hFFFF_FFFF, 32'd1, 1'b0);
        res(32'd0, 1'b0);
        check("carry_fail", fail_count, 32'd1);
        check("carry_pass", pass_count, 32'd0);
        check("carry_mismatch", mismatch, 32'd1);
        check("carry_halted", halted, 32'd0);
        step();
        check("carry_mismatch_pulse", mismatch, 32'd0);
        check("carry_fail_hold", fail_count, 32'd1);

        // 9 ops into depth 8: 9th dropped, then 8 in-order results with carry-out
        do_reset();
        for (int i = 0; i < 9; i++) begin
            op(32'hF000_0000 + 32'(i), 32'h2000_0000, i[0]);
            if (i == 7) check("ovf_before_9th", ovf_err, 32'd0);
        end
        check("ovf_after_9th", ovf_err, 32'd1);
        for (int i = 0; i < 8; i++) begin
            res(32'h1000_0000 + 32'(i) + 32'(i[0]), 1'b1);
        end
        check("ovf_drain_pass", pass_count, 32'd8);
        check("ovf_drain_fail", fail_count, 32'd0);
        check("ovf_drain_unf", unf_err, 32'd0);
        res(32'h1000_0008, 1'b1);
        check("ovf_dropped_unf", unf_err, 32'd1);
        check("ovf_dropped_pass", pass_count, 32'd8);

        // full queue with simultaneous push and pop: both happen, no overflow
        do_reset();
        for (int i = 0; i < 8; i++) begin
            op(32'(i), 32'd100, 1'b0);
        end
        op_valid = 1'b1; a = 32'd50; b = 32'd50; cin = 1'b1;
        res_valid = 1'b1; s = 32'd100; cout = 1'b0;
        step();
        op_valid = 1'b0; res_valid = 1'b0;
        check("full_both_ovf", ovf_err, 32'd0);
        check("full_both_pass", pass_count, 32'd1);
        for (int i = 1; i < 8; i++) begin
            res(32'd100 + 32'(i), 1'b0);
        end
        res(32'd101, 1'b0);
        check("full_wrap_pass", pass_count, 32'd9);
        check("full_wrap_fail", fail_count, 32'd0);
        check("full_wrap_unf", unf_err, 32'd0);

        // result with nothing queued; then simultaneous push/pop on empty queue
        do_reset();
        res(32'd5, 1'b0);
        check("unf_flag", unf_err, 32'd1);
        check("unf_pass", pass_count, 32'd0);
        check("unf_fail", fail_count, 32'd0);
        op_valid = 1'b1; a = 32'd2; b = 32'd3; cin = 1'b0;
        res_valid = 1'b1; s = 32'd5; cout = 1'b0;
        step();
        op_valid = 1'b0; res_valid = 1'b0;
        check("empty_both_pass", pass_count, 32'd0);
        res(32'd5, 1'b0);
        check("empty_both_pushed", pass_count, 32'd1);

        // halt on first mismatch; traffic ignored while halted
        do_reset();
        halt_on_fail = 1'b1;
        op(32'd10, 32'd20, 1'b0);
        res(32'd99, 1'b0);
        check("halt_fail", fail_count, 32'd1);
        check("halt_halted", halted, 32'd1);
        check("halt_mismatch", mismatch, 32'd1);
        op(32'd1, 32'd1, 1'b0);
        repeat (3) res(32'd30, 1'b0);
        check("halt_pass_ignored", pass_count, 32'd0);
        check("halt_unf_ignored", unf_err, 32'd0);
        check("halt_still", halted, 32'd1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", halted, 32'd0);
        op(32'd7, 32'd8, 1'b1);
        res(32'd16, 1'b0);
        check("resume_pass", pass_count, 32'd1);
        check("resume_fail", fail_count, 32'd1);
        check("resume_run", halted, 32'd0);
        // mismatch together with resume while running still halts
        op(32'd1, 32'd2, 1'b0);
        resume = 1'b1;
        res(32'd0, 1'b0);
        resume = 1'b0;
        check("prio_halted", halted, 32'd1);
        check("prio_fail", fail_count, 32'd2);
        halt_on_fail = 1'b0;

        // asynchronous reset with entries queued
        do_reset();
        op(32'd1, 32'd1, 1'b0);
        res(32'd2, 1'b0);
        res(32'd0, 1'b0);
        check("pre_rst_pass", pass_count, 32'd1);
        check("pre_rst_unf", unf_err, 32'd1);
        op(32'd3, 32'd3, 1'b0);
        op(32'd4, 32'd4, 1'b0);
        op(32'd5, 32'd5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pass", pass_count, 32'd0);
        check("async_rst_unf", unf_err, 32'd0);
        check("async_rst_halted", halted, 32'd0);
        step();
        rst = 1'b0;
        step();
        res(32'd6, 1'b0);
        check("post_rst_unf", unf_err, 32'd1);
        check("post_rst_pass", pass_count, 32'd0);
        check("post_rst_fail", fail_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
